// File: rtl/spi_mstr_mss.sv
// SPI master (mode 3) with a binary-indexed active-low slave-select decoder,
// a one-deep command buffer, and a received word tagged with its source slave.
module spi_mstr_mss #(
  parameter int NUM_SS      = 5,
  parameter int SS_W        = 3,
  parameter int DATA_W      = 16,
  parameter int SCLK_DIV    = 32,
  parameter int FRONT_PORCH = 8,
  parameter int BACK_PORCH  = 8,
  parameter int MIN_GAP     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] data_out,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_in,
  output logic [SS_W-1:0]   last_ss,
  output logic              ovf,
  output logic              sel_err
);
  localparam int CW = 16;
  localparam int BW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rxreg;
  logic [SS_W-1:0]   sel;
  logic              buf_valid;
  logic [SS_W-1:0]   buf_sel;
  logic [DATA_W-1:0] buf_data;
  logic              sel_ok;
  logic              store_now;

  function automatic logic [NUM_SS-1:0] ss_dec(input logic [SS_W-1:0] s);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int unsigned k = 0; k < NUM_SS; k++)
      if (SS_W'(k) == s) v[k] = 1'b0;
    return v;
  endfunction

  always_comb begin
    sel_ok    = ({1'b0, ss_sel} < (SS_W+1)'(NUM_SS));
    store_now = wrt && sel_ok && (state != IDLE) && !buf_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rxreg     <= '0;
      sel       <= '0;
      buf_valid <= 1'b0;
      buf_sel   <= '0;
      buf_data  <= '0;
      SCLK      <= 1'b1;
      MOSI      <= 1'b0;
      SS_n      <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_in   <= '0;
      last_ss   <= '0;
      ovf       <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      ovf     <= wrt && sel_ok && (state != IDLE) && buf_valid;
      sel_err <= wrt && !sel_ok;
      cnt     <= cnt + 1'b1;
      if (store_now) begin
        buf_valid <= 1'b1;
        buf_sel   <= ss_sel;
        buf_data  <= data_out;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (wrt && sel_ok) begin
            sel   <= ss_sel;
            shreg <= data_out;
            MOSI  <= data_out[DATA_W-1];
            SS_n  <= ss_dec(ss_sel);
            busy  <= 1'b1;
            state <= FRONT;
          end
        end
        FRONT: begin
          if (cnt == CW'(FRONT_PORCH-1)) begin
            state   <= SHIFT;
            SCLK    <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (cnt == CW'(SCLK_DIV/2-1)) begin
            SCLK  <= 1'b1;
            rxreg <= {rxreg[DATA_W-2:0], MISO};
          end
          if (cnt == CW'(SCLK_DIV-1)) begin
            cnt <= '0;
            if (bit_cnt == BW'(DATA_W-1)) begin
              state <= BACK;
            end else begin
              SCLK    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg << 1;
              MOSI    <= shreg[DATA_W-2];
            end
          end
        end
        BACK: begin
          if (cnt == CW'(BACK_PORCH-1)) begin
            SS_n    <= '1;
            MOSI    <= 1'b0;
            done    <= 1'b1;
            data_in <= rxreg;
            last_ss <= sel;
            cnt     <= '0;
            // a request landing in this last cycle still counts as buffered
            if (buf_valid || store_now) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          // the completion cycle is GAP with cnt==0; the buffer moves at its end
          if (cnt == '0) begin
            sel       <= buf_sel;
            shreg     <= buf_data;
            buf_valid <= 1'b0;
          end
          if (cnt == CW'(MIN_GAP)) begin
            state <= FRONT;
            SS_n  <= ss_dec(sel);
            MOSI  <= shreg[DATA_W-1];
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mstr_mss.sv
// Scoreboard bench for spi_mstr_mss: default build with MISO looped to MOSI,
// plus an 8-bit/8-slave build driven by a small mode-3 slave model.
module tb_spi_mstr_mss;
  logic        clk = 1'b0;
  logic        rst;
  logic        wrt;
  logic [2:0]  ss_sel;
  logic [15:0] data_out;
  logic        miso;
  logic        SCLK, MOSI, busy, done, ovf, sel_err;
  logic [4:0]  SS_n;
  logic [15:0] data_in;
  logic [2:0]  last_ss;

  logic        wrt2;
  logic [2:0]  ss_sel2;
  logic [7:0]  data_out2;
  logic        miso2;
  logic        SCLK2, MOSI2, busy2, done2, ovf2, sel_err2;
  logic [7:0]  SS_n2;
  logic [7:0]  data_in2;
  logic [2:0]  last_ss2;

  always #5 clk = ~clk;

  spi_mstr_mss dut (
    .clk(clk), .rst(rst), .wrt(wrt), .ss_sel(ss_sel), .data_out(data_out),
    .MISO(miso), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .busy(busy),
    .done(done), .data_in(data_in), .last_ss(last_ss), .ovf(ovf), .sel_err(sel_err)
  );

  spi_mstr_mss #(.NUM_SS(8), .SS_W(3), .DATA_W(8), .SCLK_DIV(4),
                 .FRONT_PORCH(8), .BACK_PORCH(8), .MIN_GAP(4)) dut2 (
    .clk(clk), .rst(rst), .wrt(wrt2), .ss_sel(ss_sel2), .data_out(data_out2),
    .MISO(miso2), .SCLK(SCLK2), .MOSI(MOSI2), .SS_n(SS_n2), .busy(busy2),
    .done(done2), .data_in(data_in2), .last_ss(last_ss2), .ovf(ovf2), .sel_err(sel_err2)
  );

  assign miso = MOSI;

  // slave for dut2: returns 8'h3C, changes MISO on SCLK falls 2..8
  logic [7:0] sl_sh;
  int         sl_falls;
  logic       sclk2_q;
  always @(posedge clk) begin
    sclk2_q <= SCLK2;
    if (&SS_n2) begin
      sl_sh    <= 8'h3C;
      sl_falls <= 0;
    end else if (sclk2_q && !SCLK2) begin
      sl_falls <= sl_falls + 1;
      if (sl_falls > 0) sl_sh <= {sl_sh[6:0], 1'b0};
    end
  end
  assign miso2 = sl_sh[7];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int falls = 0;
  int ovf_cnt = 0, serr_cnt = 0, done_cnt = 0;
  always @(negedge SCLK) falls++;

  typedef struct { logic [15:0] d; logic [2:0] s; int c; } exp_t;
  exp_t q[$];
  exp_t q2[$];
  exp_t e, e2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard whenever a done pulse appears
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.c);
          chk("data_in", {16'h0, data_in}, {16'h0, e.d});
          chk("last_ss", {29'h0, last_ss}, {29'h0, e.s});
        end
      end
      if (done2) begin
        if (q2.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
        else begin
          e2 = q2.pop_front();
          chk("done2_cycle", cyc, e2.c);
          chk("data_in2", {24'h0, data_in2}, {16'h0, e2.d});
          chk("last_ss2", {29'h0, last_ss2}, {29'h0, e2.s});
        end
      end
      if (ovf) ovf_cnt++;
      if (sel_err) serr_cnt++;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] s, input logic [15:0] d);
    wrt = 1'b1; ss_sel = s; data_out = d;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic [2:0] s, input int c);
    exp_t x;
    x.d = d; x.s = s; x.c = c;
    q.push_back(x);
  endtask

  initial begin
    int n, d, f0, b_ovf, b_done, b_serr;
    exp_t x;
    rst = 1'b1; wrt = 1'b0; ss_sel = '0; data_out = '0;
    wrt2 = 1'b0; ss_sel2 = '0; data_out2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_SS_n", {27'h0, SS_n}, 32'h1F);
    chk("rst_SCLK", {31'h0, SCLK}, 32'd1);
    chk("rst_MOSI", {31'h0, MOSI}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_flags", {29'h0, done, ovf, sel_err}, 32'd0);
    chk("rst_data_in", {16'h0, data_in}, 32'd0);
    chk("rst_last_ss", {29'h0, last_ss}, 32'd0);

    // single frame, loopback
    n = cyc; f0 = falls;
    push(16'hA5C3, 3'd4, n + 529);
    pulse(3'd4, 16'hA5C3);
    chk("t1_SS_n", {27'h0, SS_n}, 32'h0F);
    chk("t1_busy", {31'h0, busy}, 32'd1);
    chk("t1_MOSI_msb", {31'h0, MOSI}, 32'd1);
    wait_until(n + 8);  chk("t1_sclk_front", {31'h0, SCLK}, 32'd1);
    wait_until(n + 9);  chk("t1_sclk_fall1", {31'h0, SCLK}, 32'd0);
    wait_until(n + 24); chk("t1_sclk_low16", {31'h0, SCLK}, 32'd0);
    wait_until(n + 25); chk("t1_sclk_rise1", {31'h0, SCLK}, 32'd1);
    wait_until(n + 528); chk("t1_SS_back", {27'h0, SS_n}, 32'h0F);
    wait_until(n + 529);
    chk("t1_SS_release", {27'h0, SS_n}, 32'h1F);
    chk("t1_busy_fall", {31'h0, busy}, 32'd0);
    chk("t1_fall_count", falls - f0, 32'd16);
    wait_until(n + 532);

    // buffered back-to-back
    n = cyc; d = n + 529;
    push(16'h1234, 3'd1, d);
    push(16'h5678, 3'd2, d + 533);
    pulse(3'd1, 16'h1234);
    wait_until(n + 10);
    pulse(3'd2, 16'h5678);
    chk("t2_SS_n", {27'h0, SS_n}, 32'h1D);
    chk("t2_busy", {31'h0, busy}, 32'd1);
    wait_until(d);     chk("t2_SS_done", {27'h0, SS_n}, 32'h1F);
    chk("t2_busy_gap", {31'h0, busy}, 32'd1);
    wait_until(d + 4); chk("t2_SS_gap", {27'h0, SS_n}, 32'h1F);
    wait_until(d + 5); chk("t2_SS_next", {27'h0, SS_n}, 32'h1B);
    wait_until(d + 540);

    // three requests during one frame
    n = cyc; b_ovf = ovf_cnt; b_done = done_cnt;
    push(16'hAAAA, 3'd0, n + 529);
    push(16'h0F0F, 3'd3, n + 1062);
    pulse(3'd0, 16'hAAAA);
    wait_until(n + 20); pulse(3'd3, 16'h0F0F);
    chk("t3_no_ovf", {31'h0, ovf}, 32'd0);
    wait_until(n + 30); pulse(3'd2, 16'h1111);
    chk("t3_ovf1", {31'h0, ovf}, 32'd1);
    wait_until(n + 40); pulse(3'd1, 16'h2222);
    chk("t3_ovf2", {31'h0, ovf}, 32'd1);
    wait_until(n + 1070);
    chk("t3_ovf_count", ovf_cnt - b_ovf, 32'd2);
    chk("t3_done_count", done_cnt - b_done, 32'd2);

    // invalid selects
    b_serr = serr_cnt;
    pulse(3'd5, 16'hDEAD);
    chk("t4_sel_err5", {31'h0, sel_err}, 32'd1);
    chk("t4_SS_n5", {27'h0, SS_n}, 32'h1F);
    chk("t4_busy5", {31'h0, busy}, 32'd0);
    pulse(3'd7, 16'hBEEF);
    chk("t4_sel_err7", {31'h0, sel_err}, 32'd1);
    chk("t4_SS_n7", {27'h0, SS_n}, 32'h1F);
    chk("t4_busy7", {31'h0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_serr_count", serr_cnt - b_serr, 32'd2);

    // reset mid-SHIFT
    n = cyc; b_done = done_cnt;
    pulse(3'd2, 16'h4D2B);
    wait_until(n + 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_SS_n", {27'h0, SS_n}, 32'h1F);
    chk("t5_SCLK", {31'h0, SCLK}, 32'd1);
    chk("t5_busy", {31'h0, busy}, 32'd0);
    chk("t5_data_in", {16'h0, data_in}, 32'd0);
    chk("t5_last_ss", {29'h0, last_ss}, 32'd0);
    wait_until(n + 600);
    chk("t5_no_done", done_cnt - b_done, 32'd0);
    n = cyc;
    push(16'h7E81, 3'd3, n + 529);
    pulse(3'd3, 16'h7E81);
    wait_until(n + 532);

    // 8-bit build with slave model
    n = cyc;
    x.d = 16'h003C; x.s = 3'd6; x.c = n + 49;
    q2.push_back(x);
    wrt2 = 1'b1; ss_sel2 = 3'd6; data_out2 = 8'h81;
    @(negedge clk);
    wrt2 = 1'b0;
    chk("t6_SS_n2", {24'h0, SS_n2}, 32'hBF);
    wait_until(n + 55);
    chk("t6_busy2", {31'h0, busy2}, 32'd0);

    chk("queue_empty", q.size(), 32'd0);
    chk("queue2_empty", q2.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
